// File: rtl/ann_stage_decider.sv
// ann_stage_decider
//   Post-processing stage that follows the ANN scoring core. It accepts one
//   vector of signed class scores per EEG epoch and finds the argmax
//   sequentially, comparing one class per cycle. The winning class is the raw
//   stage, and the gap between the best and second-best scores is reported as
//   a confidence margin. A majority vote over recent epochs can optionally
//   smooth the reported stage.
//
//   Optional feature macro: STAGE_VOTE_EN
//     defined   : VOTE_DEPTH-entry history ring with a majority vote.
//     undefined : no history storage, stage = raw_class, hist_clr ignored.
//   Both builds spend one cycle in VOTE, so the latency is the same.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   score_valid  in   scores_flat holds a valid vector
//   score_ready  out  block can accept a vector (high only in IDLE)
//   scores_flat  in   class i at [i*SCORE_W +: SCORE_W], signed
//   hist_clr     in   synchronous clear of the vote history
//   stage_valid  out  result valid, held until stage_ready
//   stage_ready  in   consumer accepts the result
//   stage        out  reported (voted) stage
//   raw_class    out  argmax of the current epoch
//   margin       out  unsigned best minus second-best score
module ann_stage_decider #(
    parameter  int SCORE_W     = 16,
    parameter  int NUM_CLASSES = 4,
    parameter  int VOTE_DEPTH  = 5,
    localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           score_valid,
    output logic                           score_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
    input  logic                           hist_clr,
    output logic                           stage_valid,
    input  logic                           stage_ready,
    output logic [CLS_W-1:0]               stage,
    output logic [CLS_W-1:0]               raw_class,
    output logic [SCORE_W-1:0]             margin
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_VOTE, S_OUT} state_t;

    localparam logic [CLS_W-1:0]   LAST_IDX = CLS_W'(NUM_CLASSES - 1);
    localparam logic [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    state_t state, next_state;

    logic signed [SCORE_W-1:0] scores_q [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best, second;
    logic        [CLS_W-1:0]   best_idx, scan_idx;
    logic signed [SCORE_W-1:0] cur_score;
    logic signed [SCORE_W:0]   diff;
    logic        [CLS_W-1:0]   vote_stage;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before the clock edge.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: next_state gets a default before the case statement, so no
        // path can leave it unassigned. That default prevents a latch.
        next_state = state;
        case (state)
            S_IDLE: if (score_valid)          next_state = S_SCAN;
            S_SCAN: if (scan_idx == LAST_IDX) next_state = S_VOTE;
            S_VOTE:                           next_state = S_OUT;
            S_OUT:  if (stage_ready)          next_state = S_IDLE;
            default:                          next_state = S_IDLE;
        endcase
    end

    assign score_ready = (state == S_IDLE);
    assign stage_valid = (state == S_OUT);

    // ------------------------------------------------------------------
    // Sequential argmax datapath
    // ------------------------------------------------------------------
    assign cur_score = scores_q[scan_idx];
    // Both operands are sign-extended by one bit. The difference is never
    // negative and always fits in SCORE_W bits, so the low bits are the
    // unsigned margin.
    assign diff = {best[SCORE_W-1], best} - {second[SCORE_W-1], second};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) scores_q[i] <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            scan_idx  <= '0;
            raw_class <= '0;
            stage     <= '0;
            margin    <= '0;
        end else begin
            case (state)
                S_IDLE: if (score_valid) begin
                    for (int i = 0; i < NUM_CLASSES; i++)
                        scores_q[i] <= scores_flat[i*SCORE_W +: SCORE_W];
                    best     <= scores_flat[SCORE_W-1:0];
                    second   <= MOST_NEG;
                    best_idx <= '0;
                    scan_idx <= CLS_W'(1);
                end
                S_SCAN: begin
                    // Strict '>' keeps the lower index on ties. A score equal
                    // to the best still replaces second, which gives margin 0.
                    if (cur_score > best) begin
                        second   <= best;
                        best     <= cur_score;
                        best_idx <= scan_idx;
                    end else if (cur_score > second) begin
                        second <= cur_score;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                S_VOTE: begin
                    raw_class <= best_idx;
                    margin    <= diff[SCORE_W-1:0];
                    stage     <= vote_stage;
                end
                default: ;
            endcase
        end
    end

`ifdef STAGE_VOTE_EN
    // ------------------------------------------------------------------
    // Vote history ring and majority vote
    // ------------------------------------------------------------------
    localparam int PTR_W = (VOTE_DEPTH > 1) ? $clog2(VOTE_DEPTH) : 1;
    localparam int CNT_W = $clog2(VOTE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VOTE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(VOTE_DEPTH - 1);

    logic [CLS_W-1:0] hist [VOTE_DEPTH];
    logic [PTR_W-1:0] wr_ptr, base_ptr, next_ptr;
    logic [CNT_W-1:0] hist_cnt, base_cnt, new_cnt;
    logic [CNT_W-1:0] votes [NUM_CLASSES];
    logic [CNT_W-1:0] top_cnt;
    logic [CLS_W-1:0] top_cls;

    // A clear that arrives in VOTE acts first. The current epoch is then
    // written as the only entry.
    assign base_ptr = hist_clr ? '0 : wr_ptr;
    assign base_cnt = hist_clr ? '0 : hist_cnt;
    assign new_cnt  = (base_cnt == FULL_CNT) ? base_cnt : base_cnt + 1'b1;
    assign next_ptr = (base_ptr == LAST_PTR) ? '0 : base_ptr + 1'b1;

    // Entries fill from index 0 after a clear. While the ring is not full,
    // the valid entries are therefore exactly [0, new_cnt).
    always_comb begin
        logic [CLS_W-1:0] entry;
        entry = '0;
        for (int c = 0; c < NUM_CLASSES; c++) votes[c] = '0;
        for (int j = 0; j < VOTE_DEPTH; j++) begin
            entry = (PTR_W'(j) == base_ptr) ? best_idx : hist[j];
            if (CNT_W'(j) < new_cnt) votes[entry] = votes[entry] + 1'b1;
        end
        top_cls = '0;
        top_cnt = votes[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (votes[c] > top_cnt) begin
                top_cnt = votes[c];
                top_cls = CLS_W'(c);
            end
        end
        // The newest epoch wins a tie if it is among the maxima. Otherwise
        // the lowest tied index wins.
        vote_stage = (votes[best_idx] == top_cnt) ? best_idx : top_cls;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            hist_cnt <= '0;
        end else if (state == S_VOTE) begin
            wr_ptr   <= next_ptr;
            hist_cnt <= new_cnt;
        end else if (hist_clr) begin
            wr_ptr   <= '0;
            hist_cnt <= '0;
        end
    end

    // NOTE: the ring storage has no reset. hist_cnt alone determines which
    // entries count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (state == S_VOTE) hist[base_ptr] <= best_idx;
    end
`else
    logic unused_hist_clr;
    assign unused_hist_clr = hist_clr;
    assign vote_stage      = best_idx;
`endif

endmodule

// File: tb/tb_ann_stage_decider.sv
// tb_ann_stage_decider
//   Directed bench for ann_stage_decider with NUM_CLASSES=4, SCORE_W=16 and
//   VOTE_DEPTH=5. The expected stages follow STAGE_VOTE_EN when it is defined.
//   Otherwise the expected stage equals raw_class.
module tb_ann_stage_decider;

    localparam int SW = 16;
    localparam int NC = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           score_valid = 1'b0;
    logic           hist_clr = 1'b0;
    logic           stage_ready = 1'b0;
    logic [NC*SW-1:0] scores_flat = '0;
    logic           score_ready;
    logic           stage_valid;
    logic [CW-1:0]  stage;
    logic [CW-1:0]  raw_class;
    logic [SW-1:0]  margin;

    int n_tests = 0;
    int n_fail  = 0;

    ann_stage_decider #(.SCORE_W(SW), .NUM_CLASSES(NC), .VOTE_DEPTH(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .scores_flat (scores_flat),
        .hist_clr    (hist_clr),
        .stage_valid (stage_valid),
        .stage_ready (stage_ready),
        .stage       (stage),
        .raw_class   (raw_class),
        .margin      (margin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [NC*SW-1:0] pack(input int s0, input int s1, input int s2, input int s3);
        logic [NC*SW-1:0] r;
        r[0*SW +: SW] = s0[SW-1:0];
        r[1*SW +: SW] = s1[SW-1:0];
        r[2*SW +: SW] = s2[SW-1:0];
        r[3*SW +: SW] = s3[SW-1:0];
        return r;
    endfunction

    task automatic start_epoch(input string tag, input logic [NC*SW-1:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        scores_flat = v;
        score_valid = 1'b1;
        while (!score_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(score_ready), 1);
        @(posedge clk);
        #1 score_valid = 1'b0;
    endtask

    // Counts edges from the accept edge until stage_valid rises. It can also
    // pulse hist_clr while the DUT is in VOTE (the cycle after edge NC-1).
    task automatic wait_result(input string tag, input bit clr_in_vote);
        int n;
        n = 0;
        while (!stage_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            hist_clr = clr_in_vote && (n == NC - 1);
        end
        hist_clr = 1'b0;
        check({tag, "_latency"}, 32'(n), NC);
    endtask

    task automatic take_result(input string tag, input int er, input int es, input int em);
        check({tag, "_raw"},    32'(raw_class), 32'(er));
        check({tag, "_stage"},  32'(stage),     32'(es));
        check({tag, "_margin"}, 32'(margin),    32'(em));
        @(negedge clk);
        stage_ready = 1'b1;
        @(posedge clk);
        #1 stage_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(stage_valid), 0);
        check({tag, "_idle_ready"}, 32'(score_ready), 1);
    endtask

    task automatic run_epoch(input string tag, input logic [NC*SW-1:0] v, input bit clr_in_vote,
                             input int er, input int es, input int em);
        start_epoch(tag, v);
        wait_result(tag, clr_in_vote);
        take_result(tag, er, es, em);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t3_raw [6];
        int t3_stage [6];
        int t3_margin [6];
        logic [NC*SW-1:0] t3_vec [6];
        int t4_stage;

        t3_raw    = '{2, 2, 1, 1, 3, 3};
        t3_margin = '{5, 5, 8, 8, 1, 1};
`ifdef STAGE_VOTE_EN
        t3_stage  = '{2, 2, 2, 1, 1, 3};
        t4_stage  = 1;
`else
        t3_stage  = '{2, 2, 1, 1, 3, 3};
        t4_stage  = 2;
`endif
        for (int i = 0; i < 6; i++) begin
            case (t3_raw[i])
                1:       t3_vec[i] = pack(0, 8, 0, 0);
                2:       t3_vec[i] = pack(0, 0, 5, 0);
                default: t3_vec[i] = pack(1, 2, 3, 4);
            endcase
        end

        // Reset state.
        #12;
        check("rst_valid",  32'(stage_valid), 0);
        check("rst_ready",  32'(score_ready), 1);
        check("rst_stage",  32'(stage),       0);
        check("rst_raw",    32'(raw_class),   0);
        check("rst_margin", 32'(margin),      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1. The history is empty, so the stage follows raw.
        run_epoch("t1", pack(10, 50, -3, 20), 1'b0, 1, 1, 30);

        // Test 2. Equal top scores, then the extreme spread. With history
        // [1,0], newest 0 wins the tie; with [1,0,1], class 1 wins outright.
        run_epoch("t2_tie",  pack(7, 7, 7, 7), 1'b0, 0, 0, 0);
        run_epoch("t2_span", pack(-32768, 32767, -32768, -32768), 1'b0, 1, 1, 65535);

        // Test 4. Back-pressure in OUT, and a stray score_valid is ignored.
        start_epoch("t4", pack(5, -1, 100, 4));
        wait_result("t4", 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            scores_flat = pack(0, 0, 0, 77);
            score_valid = 1'b1;
            @(posedge clk);
            #1;
            check("t4_hold_valid",  32'(stage_valid), 1);
            check("t4_hold_stage",  32'(stage),       32'(t4_stage));
            check("t4_hold_margin", 32'(margin),      95);
            check("t4_hold_busy",   32'(score_ready), 0);
        end
        @(negedge clk);
        score_valid = 1'b0;
        take_result("t4", 2, t4_stage, 95);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("t4_no_queue", 32'(stage_valid), 0);
        end

        // Test 3. Tie rules and the oldest entry dropping out of the window.
        @(negedge clk);
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        for (int i = 0; i < 6; i++)
            run_epoch($sformatf("t3_e%0d", i), t3_vec[i], 1'b0, t3_raw[i], t3_stage[i], t3_margin[i]);

        // Test 5. Clear in IDLE, then a clear during VOTE leaves only the
        // current entry, so raw 2 beats two earlier 0s.
        @(negedge clk);
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        run_epoch("t5_a",   pack(9, 0, 0, 0), 1'b0, 0, 0, 9);
        run_epoch("t5_b",   pack(9, 0, 0, 0), 1'b0, 0, 0, 9);
        run_epoch("t5_clr", pack(0, 0, 6, 1), 1'b1, 2, 2, 5);

        // Test 6. Reset in the middle of SCAN.
        start_epoch("t6", pack(1, 2, 3, 40));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  32'(stage_valid), 0);
        check("t6_rst_ready",  32'(score_ready), 1);
        check("t6_rst_stage",  32'(stage),       0);
        check("t6_rst_raw",    32'(raw_class),   0);
        check("t6_rst_margin", 32'(margin),      0);
        @(negedge clk);
        rst_n = 1'b1;
        run_epoch("t6", pack(0, 0, 9, 0), 1'b0, 2, 2, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
